// File: rtl/coin_compositor_pkg.sv
// Shared types and defaults for the sprite compositors (coin, bird, pipe).
// Holds the screen coordinate width, the default sprite size and the RGB888 pixel type.
package coin_compositor_pkg;

    localparam int COORD_W   = 11;
    localparam int SPR_W_DEF = 16;
    localparam int SPR_H_DEF = 16;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic rgb_t make_rgb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        rgb_t p;
        p.r = r;
        p.g = g;
        p.b = b;
        return p;
    endfunction

endpackage

// File: rtl/coin_compositor_sprite_window.sv
// Sprite box test and local coordinates for one scan pixel.
// Latency: combinational. Backpressure: none, purely a function of its inputs.
// Compares are done in 12 bits so a box hanging past x/y=2047 never wraps to 0.
module sprite_window
    import coin_compositor_pkg::*;
#(
    parameter int SPR_W = SPR_W_DEF,
    parameter int SPR_H = SPR_H_DEF
) (
    input  logic               en,
    input  logic               valid,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic [COORD_W-1:0] org_x,
    input  logic [COORD_W-1:0] org_y,
    output logic               in_box,
    output logic [COORD_W-1:0] loc_x,
    output logic [COORD_W-1:0] loc_y
);

    logic [COORD_W:0] dx;
    logic [COORD_W:0] dy;
    logic             x_ok;
    logic             y_ok;

    always_comb begin
        dx     = {1'b0, pos_x} - {1'b0, org_x};
        dy     = {1'b0, pos_y} - {1'b0, org_y};
        x_ok   = (pos_x >= org_x) && (dx < (COORD_W+1)'(SPR_W));
        y_ok   = (pos_y >= org_y) && (dy < (COORD_W+1)'(SPR_H));
        in_box = en & valid & x_ok & y_ok;
        loc_x  = dx[COORD_W-1:0];
        loc_y  = dy[COORD_W-1:0];
    end

endmodule

// File: rtl/coin_compositor.sv
// Coin sprite compositor: drives the coin ROM, overlays it on the background, flags bird overlap.
// Latency: 2 cycles scan_valid->out_valid. Backpressure: none, one pixel per cycle.
module coin_compositor
    import coin_compositor_pkg::*;
#(
    parameter int SPR_W = SPR_W_DEF,
    parameter int SPR_H = SPR_H_DEF,
    parameter int OOB_X = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [10:0] coin_x,
    input  logic [10:0] coin_y,
    input  logic        coin_en,
    input  logic        scan_valid,
    input  logic [10:0] scan_x,
    input  logic [10:0] scan_y,
    input  logic [7:0]  bg_r,
    input  logic [7:0]  bg_g,
    input  logic [7:0]  bg_b,
    input  logic        bird_opaque,
    output logic [10:0] spr_ix,
    output logic [10:0] spr_iy,
    input  logic [7:0]  spr_r,
    input  logic [7:0]  spr_g,
    input  logic [7:0]  spr_b,
    input  logic        spr_mask,
    output logic        out_valid,
    output logic [7:0]  out_r,
    output logic [7:0]  out_g,
    output logic [7:0]  out_b,
    output logic        coin_hit
);

    logic [COORD_W-1:0] cx_q, cx_d;
    logic [COORD_W-1:0] cy_q, cy_d;
    logic               en_q, en_d;
    logic               hit_acc_q, hit_acc_d;
    logic               coin_hit_q, coin_hit_d;
    logic               v1_q, v1_d;
    logic               in1_q, in1_d;
    logic [COORD_W-1:0] lx1_q, lx1_d;
    rgb_t               bg1_q, bg1_d;
    logic               bird1_q, bird1_d;
    logic               out_v_q, out_v_d;
    rgb_t               out_rgb_q, out_rgb_d;

    logic               in_box;
    logic [COORD_W-1:0] loc_x;
    logic [COORD_W-1:0] loc_y;
    logic               hit_now;

    // The latch mux output feeds the window so a pixel coincident with frame_start sees the new coin.
    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        en_d = en_q;
        if (frame_start) begin
            cx_d = coin_x;
            cy_d = coin_y;
            en_d = coin_en;
        end
    end

    sprite_window #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_window (
        .en     (en_d),
        .valid  (scan_valid),
        .pos_x  (scan_x),
        .pos_y  (scan_y),
        .org_x  (cx_d),
        .org_y  (cy_d),
        .in_box (in_box),
        .loc_x  (loc_x),
        .loc_y  (loc_y)
    );

    // Row goes out in stage 0 for the ROM's row register; column follows a cycle later.
    assign spr_iy = (rst_n && in_box) ? loc_y : '0;
    assign spr_ix = rst_n ? lx1_q : '0;

    always_comb begin
        v1_d    = scan_valid;
        in1_d   = in_box;
        lx1_d   = in_box ? loc_x : COORD_W'(OOB_X);
        bg1_d   = make_rgb(bg_r, bg_g, bg_b);
        bird1_d = bird_opaque;
    end

    always_comb begin
        hit_now    = v1_q & in1_q & spr_mask & bird1_q;
        hit_acc_d  = hit_now | (hit_acc_q & ~frame_start);
        coin_hit_d = frame_start & hit_acc_q;
        out_v_d    = v1_q;
        out_rgb_d  = '0;
        if (v1_q) begin
            out_rgb_d = (in1_q & spr_mask) ? make_rgb(spr_r, spr_g, spr_b) : bg1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx_q       <= '0;
            cy_q       <= '0;
            en_q       <= 1'b0;
            hit_acc_q  <= 1'b0;
            coin_hit_q <= 1'b0;
            v1_q       <= 1'b0;
            in1_q      <= 1'b0;
            lx1_q      <= COORD_W'(OOB_X);
            bg1_q      <= '0;
            bird1_q    <= 1'b0;
            out_v_q    <= 1'b0;
            out_rgb_q  <= '0;
        end else begin
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            en_q       <= en_d;
            hit_acc_q  <= hit_acc_d;
            coin_hit_q <= coin_hit_d;
            v1_q       <= v1_d;
            in1_q      <= in1_d;
            lx1_q      <= lx1_d;
            bg1_q      <= bg1_d;
            bird1_q    <= bird1_d;
            out_v_q    <= out_v_d;
            out_rgb_q  <= out_rgb_d;
        end
    end

    assign out_valid = out_v_q;
    assign out_r     = out_rgb_q.r;
    assign out_g     = out_rgb_q.g;
    assign out_b     = out_rgb_q.b;
    assign coin_hit  = coin_hit_q;

endmodule

// File: tb/tb_coin_compositor.sv
// Scoreboard bench for coin_compositor with a small coin ROM model (row registered, column combinational).
module tb_coin_compositor;

    logic        clk;
    logic        rst_n;
    logic        frame_start;
    logic [10:0] coin_x, coin_y;
    logic        coin_en;
    logic        scan_valid;
    logic [10:0] scan_x, scan_y;
    logic [7:0]  bg_r, bg_g, bg_b;
    logic        bird_opaque;
    logic [10:0] spr_ix, spr_iy;
    logic [7:0]  spr_r, spr_g, spr_b;
    logic        spr_mask;
    logic        out_valid;
    logic [7:0]  out_r, out_g, out_b;
    logic        coin_hit;

    int          n_chk;
    int          n_fail;
    logic [23:0] sb[$];
    logic [23:0] exp_px;
    logic [10:0] rom_row;

    localparam logic [23:0] BG  = 24'h202020;
    localparam logic [23:0] BG2 = 24'h112233;

    coin_compositor #(.SPR_W(16), .SPR_H(16), .OOB_X(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .coin_x      (coin_x),
        .coin_y      (coin_y),
        .coin_en     (coin_en),
        .scan_valid  (scan_valid),
        .scan_x      (scan_x),
        .scan_y      (scan_y),
        .bg_r        (bg_r),
        .bg_g        (bg_g),
        .bg_b        (bg_b),
        .bird_opaque (bird_opaque),
        .spr_ix      (spr_ix),
        .spr_iy      (spr_iy),
        .spr_r       (spr_r),
        .spr_g       (spr_g),
        .spr_b       (spr_b),
        .spr_mask    (spr_mask),
        .out_valid   (out_valid),
        .out_r       (out_r),
        .out_g       (out_g),
        .out_b       (out_b),
        .coin_hit    (coin_hit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Coin ROM: opaque for columns 1..14, colour encodes row and column.
    initial rom_row = '0;
    always @(posedge clk) rom_row <= spr_iy;
    assign spr_mask = (spr_ix != 11'd0) && (spr_ix < 11'd15) && (rom_row < 11'd16);
    assign spr_r    = 8'h80 | rom_row[7:0];
    assign spr_g    = spr_ix[7:0];
    assign spr_b    = 8'hC0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL out_valid: pixel 0x%0h with nothing expected at %0t", {out_r, out_g, out_b}, $time);
                end else begin
                    exp_px = sb.pop_front();
                    chk("out_rgb", {8'h00, out_r, out_g, out_b}, {8'h00, exp_px});
                end
            end else begin
                chk("idle_out_rgb", {8'h00, out_r, out_g, out_b}, 32'h0);
            end
        end
    end

    task automatic pix(input logic [10:0] x, input logic [10:0] y, input logic [23:0] bgv,
                       input logic bird, input logic [23:0] exp);
        @(posedge clk); #1;
        scan_valid  = 1'b1;
        scan_x      = x;
        scan_y      = y;
        {bg_r, bg_g, bg_b} = bgv;
        bird_opaque = bird;
        sb.push_back(exp);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        scan_valid  = 1'b0;
        bird_opaque = 1'b0;
    endtask

    task automatic frame(input logic [10:0] fx, input logic [10:0] fy, input logic fe, input logic exp_hit,
                         input logic px_vld, input logic [10:0] px, input logic [10:0] py,
                         input logic bird, input logic [23:0] exp);
        @(posedge clk); #1;
        frame_start = 1'b1;
        coin_x      = fx;
        coin_y      = fy;
        coin_en     = fe;
        scan_valid  = px_vld;
        scan_x      = px;
        scan_y      = py;
        {bg_r, bg_g, bg_b} = BG;
        bird_opaque = bird;
        if (px_vld) sb.push_back(exp);
        @(posedge clk); #1;
        frame_start = 1'b0;
        scan_valid  = 1'b0;
        bird_opaque = 1'b0;
        chk("coin_hit", 32'(coin_hit), 32'(exp_hit));
        @(posedge clk); #1;
        chk("coin_hit_one_cycle", 32'(coin_hit), 32'h0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        frame_start = 1'b0;
        coin_x = '0; coin_y = '0; coin_en = 1'b0;
        scan_valid = 1'b0; scan_x = '0; scan_y = '0;
        {bg_r, bg_g, bg_b} = BG;
        bird_opaque = 1'b0;

        #12;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_rgb", {8'h00, out_r, out_g, out_b}, 32'h0);
        chk("rst_coin_hit", 32'(coin_hit), 32'h0);
        chk("rst_spr_ix", 32'(spr_ix), 32'h0);
        chk("rst_spr_iy", 32'(spr_iy), 32'h0);
        #10 rst_n = 1'b1;

        // First frame after reset: nothing to report.
        frame(11'd100, 11'd50, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 24'h0);

        // Row y=57 across the coin at (100,50).
        pix(11'd99, 11'd57, BG, 1'b0, BG);        #1 chk("iy_x99", 32'(spr_iy), 32'd0);
        idle();                                    chk("ix_x99", 32'(spr_ix), 32'd16);
        pix(11'd110, 11'd57, BG, 1'b0, 24'h870AC0); #1 chk("iy_x110", 32'(spr_iy), 32'd7);
        idle();                                    chk("ix_x110", 32'(spr_ix), 32'd10);
        pix(11'd116, 11'd57, BG, 1'b0, BG);       #1 chk("iy_x116", 32'(spr_iy), 32'd0);
        idle();                                    chk("ix_x116", 32'(spr_ix), 32'd16);
        pix(11'd100, 11'd57, BG, 1'b0, BG);       #1 chk("iy_x100", 32'(spr_iy), 32'd7);
        idle();                                    chk("ix_x100", 32'(spr_ix), 32'd0);

        // Back-to-back pixels, then the vertical box edges.
        pix(11'd101, 11'd57, BG, 1'b0, 24'h8701C0);
        pix(11'd102, 11'd57, BG, 1'b0, 24'h8702C0);
        pix(11'd103, 11'd57, BG, 1'b0, 24'h8703C0);
        pix(11'd106, 11'd57, BG, 1'b0, 24'h8706C0);
        pix(11'd115, 11'd57, BG, 1'b0, BG);
        pix(11'd110, 11'd49, BG, 1'b0, BG);
        pix(11'd110, 11'd65, BG, 1'b0, 24'h8F0AC0);
        pix(11'd110, 11'd66, BG, 1'b0, BG);
        idle();

        // coin_x moves without frame_start: old position still composited.
        coin_x = 11'd300;
        pix(11'd110, 11'd57, BG, 1'b0, 24'h870AC0);
        pix(11'd310, 11'd57, BG, 1'b0, BG);
        idle();
        // New position takes effect for the pixel sharing the frame_start cycle.
        frame(11'd300, 11'd50, 1'b1, 1'b0, 1'b1, 11'd310, 11'd57, 1'b0, 24'h870AC0);

        // Bird over transparent / out-of-box pixels only: no hit.
        pix(11'd300, 11'd53, BG, 1'b1, BG);
        pix(11'd299, 11'd53, BG, 1'b1, BG);
        pix(11'd306, 11'd53, BG, 1'b0, 24'h8306C0);
        idle();
        frame(11'd300, 11'd50, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 24'h0);

        // Bird over opaque coin pixel: reported after the next frame_start.
        pix(11'd306, 11'd53, BG, 1'b1, 24'h8306C0);
        idle();
        idle();
        idle();
        frame(11'd300, 11'd50, 1'b1, 1'b1, 1'b0, 11'd0, 11'd0, 1'b0, 24'h0);

        // Overlap whose hit lands on the frame_start edge belongs to the new frame.
        pix(11'd310, 11'd53, BG, 1'b0, 24'h830AC0);
        idle();
        pix(11'd306, 11'd53, BG, 1'b1, 24'h8306C0);
        frame(11'd300, 11'd50, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 24'h0);
        frame(11'd2040, 11'd2040, 1'b1, 1'b1, 1'b0, 11'd0, 11'd0, 1'b0, 24'h0);

        // Coin near the bottom-right corner: no wrap to small coordinates.
        pix(11'd2045, 11'd2045, BG2, 1'b0, 24'h8505C0); #1 chk("iy_corner", 32'(spr_iy), 32'd5);
        pix(11'd3, 11'd2045, BG2, 1'b0, BG2);            #1 chk("iy_wrap_x", 32'(spr_iy), 32'd0);
        pix(11'd7, 11'd2045, BG2, 1'b0, BG2);
        pix(11'd2045, 11'd3, BG2, 1'b0, BG2);
        idle();
        frame(11'd100, 11'd50, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 24'h0);

        // Overlap then reset mid-line: pipeline flushed, overlap forgotten.
        pix(11'd110, 11'd57, BG, 1'b1, 24'h870AC0);
        pix(11'd111, 11'd57, BG, 1'b0, 24'h870BC0);
        idle();
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_out_rgb", {8'h00, out_r, out_g, out_b}, 32'h0);
        chk("midrst_coin_hit", 32'(coin_hit), 32'h0);
        chk("midrst_spr_ix", 32'(spr_ix), 32'h0);
        chk("midrst_spr_iy", 32'(spr_iy), 32'h0);
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        // Latched coin state is cleared too, so no coin at (0,0) is drawn.
        pix(11'd5, 11'd5, BG, 1'b1, BG);
        idle();
        frame(11'd100, 11'd50, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 24'h0);

        repeat (4) idle();
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/coin_compositor.md
# coin_compositor

Consumer side of the coin sprite ROM interface. Takes the display scan position and the background pixel, drives the sprite ROM's local coordinate inputs, and compensates for the ROM's one-cycle row latency. Composites the returned RGB and mask over the background. Accumulates a per-frame bird/coin overlap flag for the game-logic FSM. Sits between the background generator and the VGA output register stage.

## Interface

Parameters:
- SPR_W, 16, sprite width in pixels.
- SPR_H, 16, sprite height in pixels.
- OOB_X, 16, local x driven to the ROM when the pixel is outside the box (ROM mask is 0 there).

Ports:
- clk  in  1  pixel clock, single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse before the first active pixel of each frame.
- coin_x, coin_y  in  11 each  sprite top-left in screen coordinates; sampled only on frame_start.
- coin_en  in  1  coin visible/collectable; sampled only on frame_start.
- scan_valid  in  1  qualifies scan_x, scan_y, bg_r/g/b, bird_opaque.
- scan_x, scan_y  in  11 each  current screen pixel.
- bg_r, bg_g, bg_b  in  8 each  background pixel.
- bird_opaque  in  1  bird sprite opaque at this pixel.
- spr_ix, spr_iy  out  11 each  local coordinates to the sprite ROM.
- spr_r, spr_g, spr_b  in  8 each  ROM colour (column combinational, row registered in ROM).
- spr_mask  in  1  ROM opacity.
- out_valid  out  1  output pixel qualifier.
- out_r, out_g, out_b  out  8 each  composited pixel.
- coin_hit  out  1  one-cycle pulse reporting overlap in the previous frame.

## Operation

- Frame latch: on frame_start, load cx<=coin_x, cy<=coin_y, en<=coin_en. Also set coin_hit<=hit_acc and clear hit_acc. A scan_valid pixel in the same cycle uses the newly latched values.
- Stage 0 (combinational on inputs):
  - Compute dx=scan_x-cx and dy=scan_y-cy in 12-bit.
  - in_box = en & scan_valid & (scan_x>=cx) & (dx<SPR_W) & (scan_y>=cy) & (dy<SPR_H), using 12-bit compares so that cx+SPR_W beyond 2047 does not wrap.
  - spr_iy = in_box ? dy[10:0] : 0, driven combinationally so the ROM's row register captures it at this edge.
- Stage 1 (registered): v1, in1, lx1 (= in_box ? dx : OOB_X), bg1, bird1.
  - spr_ix = lx1, so the ROM returns this pixel's colour/mask combinationally during stage 1.
- Stage 2 (registered outputs):
  - out_valid <= v1.
  - out_rgb <= (in1 & spr_mask) ? spr_rgb : bg1.
  - When v1=0, out_rgb <= 0.
- Hit accumulation: if v1 & in1 & spr_mask & bird1, set hit_acc.
  - hit_acc stays set until the next frame_start.
  - If a hit and frame_start occur in the same cycle, the hit belongs to the new frame: clear-then-set, so hit_acc=1 after the edge.
- coin_hit is high for exactly one cycle after a frame_start whose prior frame saw an overlap, otherwise 0.

## Timing

- Latency scan_valid→out_valid: 2 cycles. Back-to-back pixels are accepted every cycle, with no stalls and no backpressure.
- Reset values (async on rst_n low):
  - cx, cy, en = 0
  - hit_acc, coin_hit = 0
  - all pipeline valids = 0
  - out_rgb = 0
- spr_ix and spr_iy are 0 while rst_n is low.
- Reset mid-frame: the pipeline flushes immediately and out_valid=0 on the next edge. Overlap information is lost and no coin_hit is produced for that frame.
- A frame_start with no preceding frame (first after reset) produces coin_hit=0.
- Gaps in scan_valid do not disturb the stage alignment, because the valid bit travels with the data.

## Structure

- Shared package:
  - SPR_W/SPR_H defaults.
  - Coordinate width constant (11).
  - RGB888 pixel struct/typedef, reused by the bird and pipe compositors.
- One natural sub-module, sprite_window: stage-0 box test and local-coordinate subtraction. It is reusable for the bird and pipe sprites.
- The compositor instantiates sprite_window and connects to the existing coin ROM externally, not inside this block.

## Test plan

- Place coin at (100,50), en=1, and scan the row y=57 with a bg of 0x202020. Hit at x=106 or outside the box is determined by the ROM mask:
  - At x=110 (mask=1), out_rgb = ROM value, 2 cycles after input.
  - At x=99 and x=116, out_rgb = 0x202020.
  - At y=57, spr_iy=7 and spr_ix=OOB_X for out-of-box pixels.
- Coin at (2040,2040): pixels at x=2045 are in the box, and x=0..7 are not, so there is no wraparound artefact.
- Change coin_x mid-frame with no frame_start: the composite stays at the old position. After frame_start, the new position is used from that same-cycle pixel.
- bird_opaque=1 over an opaque coin pixel at frame N: a single-cycle coin_hit follows frame_start N+1. Frame N+1 with no overlap gives coin_hit=0 after the next frame_start.
- Overlap pixel in the same cycle as frame_start: hit_acc=1 afterwards, and it is reported one frame later.
- Assert rst_n low mid-line: out_valid=0, out_rgb=0, coin_hit=0, and the next frame_start produces no coin_hit.
